// File: rtl/xm_wb_pkg.sv
// Shared types and helpers for the X-Makina register-file writeback sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package xm_wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_PTR  = 2'd1,
        WR_DATA = 2'd2
    } wb_state_t;

    localparam int BYTE      = 8;
    // Byte count for the default 16-bit word.
    localparam int BYTES     = 16 / BYTE;
    // Upper bound on byte lanes the helper can describe (256-bit words).
    localparam int MAX_BYTES = 32;

    // Byte-enable pattern: only lane 0 for a byte write, every lane of an
    // nbytes-wide word otherwise. Callers size-cast the result to their width.
    function automatic logic [MAX_BYTES-1:0] byte_en(input logic byte_sel, input int nbytes);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if ((i < nbytes) && (!byte_sel || (i == 0))) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/reg_writeback_sequencer.sv
// Turns writeback requests into one or two registered register-file writes (pointer first, then data).
// Latency: the first write is presented the cycle after accept; a pointer request adds one more cycle.
// Backpressure: wb_ready is low while a held data write is pending or while flush is high.
//
// Ports: clk/reset (async active-low); wb_* request side (valid/ready);
// flush aborts pending work; REG_wr/wr_addr/wr_data/wb_done drive the register file.
module reg_writeback_sequencer
    import xm_wb_pkg::*;
#(
    parameter int WORD      = 16,
    parameter int REGISTERS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wb_valid,
    output logic                         wb_ready,
    input  logic [$clog2(REGISTERS)-1:0] wb_dst,
    input  logic [WORD-1:0]              wb_data,
    input  logic                         wb_byte,
    input  logic                         wb_ptr_en,
    input  logic [$clog2(REGISTERS)-1:0] wb_ptr_reg,
    input  logic [WORD-1:0]              wb_ptr_data,
    input  logic                         flush,
    output logic [WORD/BYTE-1:0]         REG_wr,
    output logic [$clog2(REGISTERS)-1:0] wr_addr,
    output logic [WORD-1:0]              wr_data,
    output logic                         wb_done
);

    localparam int AW = $clog2(REGISTERS);
    localparam int NB = WORD / BYTE;

    wb_state_t       state_q, state_d;
    logic [NB-1:0]   reg_wr_q, reg_wr_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD-1:0] wr_data_q, wr_data_d;
    logic            wb_done_q, wb_done_d;

    // Data write parked while the pointer write is on the port.
    logic [AW-1:0]   hold_dst_q, hold_dst_d;
    logic [WORD-1:0] hold_data_q, hold_data_d;
    logic            hold_byte_q, hold_byte_d;

    assign wb_ready = !flush && (state_q != WR_PTR);

    always_comb begin
        state_d     = IDLE;
        reg_wr_d    = '0;
        wb_done_d   = 1'b0;
        // Address/data hold their last values while no write is presented.
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        hold_dst_d  = hold_dst_q;
        hold_data_d = hold_data_q;
        hold_byte_d = hold_byte_q;

        if (flush) begin
            // Drop any parked data write; whatever is on the port now still lands.
            hold_dst_d  = '0;
            hold_data_d = '0;
            hold_byte_d = 1'b0;
        end else if (state_q == WR_PTR) begin
            state_d   = WR_DATA;
            wr_addr_d = hold_dst_q;
            wr_data_d = hold_data_q;
            reg_wr_d  = NB'(byte_en(hold_byte_q, NB));
            wb_done_d = 1'b1;
        end else if (wb_valid && wb_ready) begin
            if (wb_ptr_en) begin
                // Pointer goes first so a same-register data write wins.
                state_d     = WR_PTR;
                wr_addr_d   = wb_ptr_reg;
                wr_data_d   = wb_ptr_data;
                reg_wr_d    = NB'(byte_en(1'b0, NB));
                hold_dst_d  = wb_dst;
                hold_data_d = wb_data;
                hold_byte_d = wb_byte;
            end else begin
                state_d   = WR_DATA;
                wr_addr_d = wb_dst;
                wr_data_d = wb_data;
                reg_wr_d  = NB'(byte_en(wb_byte, NB));
                wb_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            reg_wr_q    <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wb_done_q   <= 1'b0;
            hold_dst_q  <= '0;
            hold_data_q <= '0;
            hold_byte_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_wr_q    <= reg_wr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wb_done_q   <= wb_done_d;
            hold_dst_q  <= hold_dst_d;
            hold_data_q <= hold_data_d;
            hold_byte_q <= hold_byte_d;
        end
    end

    assign REG_wr  = reg_wr_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wb_done = wb_done_q;

endmodule

// File: tb/tb_reg_writeback_sequencer.sv
module tb_reg_writeback_sequencer;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_dst;
    logic [15:0] wb_data;
    logic        wb_byte;
    logic        wb_ptr_en;
    logic [2:0]  wb_ptr_reg;
    logic [15:0] wb_ptr_data;
    logic        flush;
    logic [1:0]  REG_wr;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wb_done;

    int checks;
    int errors;

    logic [15:0] rf [8];

    reg_writeback_sequencer #(.WORD(16), .REGISTERS(8)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_dst(wb_dst), .wb_data(wb_data), .wb_byte(wb_byte),
        .wb_ptr_en(wb_ptr_en), .wb_ptr_reg(wb_ptr_reg), .wb_ptr_data(wb_ptr_data),
        .flush(flush),
        .REG_wr(REG_wr), .wr_addr(wr_addr), .wr_data(wr_data), .wb_done(wb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file image built from whatever the DUT presents.
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (REG_wr[b]) rf[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_dst = 0; wb_data = 0; wb_byte = 0;
        wb_ptr_en = 0; wb_ptr_reg = 0; wb_ptr_data = 0; flush = 0;
    endtask

    task automatic req(input logic [2:0] d, input logic [15:0] dat, input logic by,
                       input logic pe, input logic [2:0] pr, input logic [15:0] pd);
        wb_valid = 1; wb_dst = d; wb_data = dat; wb_byte = by;
        wb_ptr_en = pe; wb_ptr_reg = pr; wb_ptr_data = pd;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        #12;
        checks++;
        if (REG_wr !== 2'b00 || wr_addr !== 3'd0 || wr_data !== 16'h0 || wb_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: REG_wr=%b addr=%0d data=%h done=%b, want 00/0/0000/0",
                     REG_wr, wr_addr, wr_data, wb_done);
        end
        reset = 1;
        step();
        checks++;
        if (wb_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", wb_ready);
        end
    endtask

    task automatic test_word_write();
        req(3'd3, 16'hBEEF, 0, 0, 0, 0);
        step();
        idle_inputs();
        checks++;
        if (REG_wr !== 2'b11 || wr_addr !== 3'd3 || wr_data !== 16'hBEEF || wb_done !== 1'b1) begin
            errors++;
            $display("FAIL word_write: REG_wr=%b addr=%0d data=%h done=%b, want 11/3/BEEF/1",
                     REG_wr, wr_addr, wr_data, wb_done);
        end
        step();
        checks++;
        if (REG_wr !== 2'b00 || wb_done !== 1'b0 || wr_addr !== 3'd3 || wr_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL word_after: REG_wr=%b done=%b addr=%0d data=%h, want 00/0/3/BEEF",
                     REG_wr, wb_done, wr_addr, wr_data);
        end
    endtask

    task automatic test_byte_write();
        req(3'd5, 16'h12AB, 1, 0, 0, 0);
        step();
        idle_inputs();
        checks++;
        if (REG_wr !== 2'b01 || wr_addr !== 3'd5 || wr_data !== 16'h12AB || wb_done !== 1'b1) begin
            errors++;
            $display("FAIL byte_write: REG_wr=%b addr=%0d data=%h done=%b, want 01/5/12AB/1",
                     REG_wr, wr_addr, wr_data, wb_done);
        end
        step();
    endtask

    task automatic test_ptr_seq();
        req(3'd1, 16'h00FF, 0, 1, 3'd4, 16'h2002);
        step();
        idle_inputs();
        #1;
        checks++;
        if (REG_wr !== 2'b11 || wr_addr !== 3'd4 || wr_data !== 16'h2002 || wb_done !== 1'b0 || wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL ptr_first: REG_wr=%b addr=%0d data=%h done=%b rdy=%b, want 11/4/2002/0/0",
                     REG_wr, wr_addr, wr_data, wb_done, wb_ready);
        end
        step();
        checks++;
        if (REG_wr !== 2'b11 || wr_addr !== 3'd1 || wr_data !== 16'h00FF || wb_done !== 1'b1) begin
            errors++;
            $display("FAIL ptr_data: REG_wr=%b addr=%0d data=%h done=%b, want 11/1/00FF/1",
                     REG_wr, wr_addr, wr_data, wb_done);
        end
        step();
    endtask

    task automatic test_same_reg();
        req(3'd2, 16'h0077, 1, 1, 3'd2, 16'h1000);
        step();
        idle_inputs();
        step();
        step();
        checks++;
        if (rf[2] !== 16'h1077) begin
            errors++; $display("FAIL same_reg: r2=%h want 1077", rf[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        vals[0] = 16'hA001; vals[1] = 16'hB002; vals[2] = 16'hC003;
        for (int i = 0; i < 3; i++) begin
            req(3'(i + 5), vals[i], 0, 0, 0, 0);
            #1;
            checks++;
            if (wb_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, wb_ready);
            end
            step();
            checks++;
            if (REG_wr !== 2'b11 || wr_addr !== 3'(i + 5) || wr_data !== vals[i] || wb_done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_write%0d: REG_wr=%b addr=%0d data=%h done=%b, want 11/%0d/%h/1",
                         i, REG_wr, wr_addr, wr_data, wb_done, i + 5, vals[i]);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_flush();
        req(3'd6, 16'h5555, 0, 1, 3'd7, 16'h7777);
        step();
        idle_inputs();
        flush = 1;
        #1;
        checks++;
        if (wb_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b want 0", wb_ready);
        end
        step();
        flush = 0;
        checks++;
        if (REG_wr !== 2'b00 || wb_done !== 1'b0) begin
            errors++; $display("FAIL flush_next: REG_wr=%b done=%b want 00/0", REG_wr, wb_done);
        end
        step();
        checks++;
        if (REG_wr !== 2'b00 || wb_done !== 1'b0) begin
            errors++; $display("FAIL flush_no_data: REG_wr=%b done=%b want 00/0", REG_wr, wb_done);
        end
        // flush with valid: no accept
        req(3'd1, 16'h1111, 0, 0, 0, 0);
        flush = 1;
        step();
        idle_inputs();
        checks++;
        if (REG_wr !== 2'b00) begin
            errors++; $display("FAIL flush_valid: REG_wr=%b want 00", REG_wr);
        end
        step();
    endtask

    task automatic test_async_reset();
        req(3'd4, 16'h4321, 0, 0, 0, 0);
        step();
        idle_inputs();
        #2;
        reset = 0;
        #1;
        checks++;
        if (REG_wr !== 2'b00 || wr_data !== 16'h0 || wr_addr !== 3'd0 || wb_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: REG_wr=%b addr=%0d data=%h done=%b want 00/0/0000/0",
                     REG_wr, wr_addr, wr_data, wb_done);
        end
        reset = 1;
        // Reset in the middle of a pointer sequence drops the data write.
        req(3'd3, 16'h9999, 0, 1, 3'd0, 16'h8888);
        step();
        idle_inputs();
        #2;
        reset = 0;
        #2;
        reset = 1;
        step();
        checks++;
        if (REG_wr !== 2'b00 || wb_done !== 1'b0) begin
            errors++; $display("FAIL reset_midreq: REG_wr=%b done=%b want 00/0", REG_wr, wb_done);
        end
        step();
    endtask

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        logic [1:0]  be;
        logic        done;
    } wr_t;

    task automatic test_random();
        wr_t q[$];
        wr_t cur;
        logic exp_rdy;
        logic have_last;
        logic [2:0]  last_a;
        logic [15:0] last_d;
        have_last = 0; last_a = 0; last_d = 0;
        for (int n = 0; n < 400; n++) begin
            wb_valid    = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 9) == 0);
            wb_ptr_en   = ($urandom_range(0, 9) < 4);
            wb_byte     = $urandom_range(0, 1);
            wb_dst      = 3'($urandom_range(0, 7));
            wb_ptr_reg  = 3'($urandom_range(0, 7));
            wb_data     = 16'($urandom);
            wb_ptr_data = 16'($urandom);
            #1;
            exp_rdy = !flush && (q.size() == 0);
            checks++;
            if (wb_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, wb_ready, exp_rdy);
            end
            // Expected write list: pointer (if any) then data, one per cycle.
            cur = '{a: 3'd0, d: 16'h0, be: 2'b00, done: 1'b0};
            if (flush) begin
                q.delete();
            end else begin
                if (wb_valid && exp_rdy) begin
                    if (wb_ptr_en) q.push_back('{a: wb_ptr_reg, d: wb_ptr_data, be: 2'b11, done: 1'b0});
                    q.push_back('{a: wb_dst, d: wb_data, be: (wb_byte ? 2'b01 : 2'b11), done: 1'b1});
                end
                if (q.size() > 0) cur = q.pop_front();
            end
            if (cur.be != 2'b00) begin
                have_last = 1; last_a = cur.a; last_d = cur.d;
            end
            step();
            checks++;
            if (REG_wr !== cur.be || wb_done !== cur.done ||
                (have_last && (wr_addr !== last_a || wr_data !== last_d))) begin
                errors++;
                $display("FAIL rnd_write@%0d: REG_wr=%b done=%b addr=%0d data=%h, want %b/%b/%0d/%h",
                         n, REG_wr, wb_done, wr_addr, wr_data, cur.be, cur.done, last_a, last_d);
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word_write();
        test_byte_write();
        test_ptr_seq();
        test_same_reg();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback_sequencer.md
Name: reg_writeback_sequencer

Overview:
- Writer-side front end for the X-Makina register file.
- Accepts writeback requests from the execute/memory stage over a valid/ready handshake.
- Converts each request into one or two registered write cycles on the register file write port: byte enables, write address and write data.
- Auto-increment and auto-decrement addressing modes need a second write that updates the pointer register; this block sequences both writes and resolves ordering.

Parameters:
- WORD, 16, register width in bits; must be a multiple of 8.
- REGISTERS, 8, number of registers; address width is $clog2(REGISTERS).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- wb_valid  in  1  request valid.
- wb_ready  out  1  request accept; a transfer occurs on a posedge where wb_valid && wb_ready.
- wb_dst  in  $clog2(REGISTERS)  destination register for the data write.
- wb_data  in  WORD  data to write.
- wb_byte  in  1  1 = write the low byte only; 0 = full-word write.
- wb_ptr_en  in  1  1 = the request also carries a pointer update.
- wb_ptr_reg  in  $clog2(REGISTERS)  pointer register to update.
- wb_ptr_data  in  WORD  new pointer value; always written as a full word.
- flush  in  1  synchronous abort of any pending write.
- REG_wr  out  WORD/8  byte write enables to the register file.
- wr_addr  out  $clog2(REGISTERS)  write address.
- wr_data  out  WORD  write data.
- wb_done  out  1  high during the cycle the final write of a request is presented.

Behaviour:
- All outputs except wb_ready are registered.
  - Reset (reset=0) forces these values immediately, independent of clk: REG_wr=0, wr_addr=0, wr_data=0, wb_done=0, state=IDLE, hold registers=0.
  - Reset taking effect mid-request discards the request; no partial write is presented after reset is released.
- States:
  - IDLE: no write presented.
  - WR_PTR: pointer write presented; data write pending in the hold registers.
  - WR_DATA: data write presented.
- wb_ready is combinational: wb_ready = !flush && state != WR_PTR. It is high in IDLE and in WR_DATA, which allows back-to-back requests.
- Accept at edge N, no pointer update:
  - Next state WR_DATA.
  - Cycle N+1 presents wr_addr=wb_dst and wr_data=wb_data.
  - REG_wr = 1 (lowest byte only) if wb_byte, else all ones.
  - wb_done=1.
- Accept at edge N with wb_ptr_en=1:
  - Next state WR_PTR.
  - Cycle N+1 presents wr_addr=wb_ptr_reg, wr_data=wb_ptr_data, REG_wr=all ones, wb_done=0.
  - wb_dst, wb_data and wb_byte are latched into the hold registers.
  - Next state WR_DATA: cycle N+2 presents the held data write with wb_done=1.
- Ordering rule: the pointer write always precedes the data write. If wb_ptr_reg == wb_dst, the data value is final (data wins), and for a byte data write the pointer's high byte survives.
- WR_DATA transitions:
  - New accept: go to WR_DATA or WR_PTR per the new request.
  - No accept: go to IDLE with REG_wr=0, wb_done=0.
- IDLE transitions: behaves like WR_DATA without a pending write.
- Throughput: 1 request per cycle without pointer updates; 1 per 2 cycles with them.
- flush=1 at a posedge:
  - Next state IDLE; next-cycle REG_wr=0, wb_done=0; hold registers invalidated.
  - A write already presented in the current cycle still completes, since the register file samples it.
  - flush together with wb_valid: no accept, because wb_ready=0.
- wr_addr and wr_data keep their last values while REG_wr=0.
- No arithmetic is performed; the pointer value is computed upstream.

Decomposition:
- Package xm_wb_pkg:
  - typedef enum wb_state_t {IDLE, WR_PTR, WR_DATA}.
  - Localparams BYTE=8 and BYTES=WORD/BYTE.
  - Function byte_en(byte_sel) returning the REG_wr pattern.
- No sub-module: a single FSM plus hold registers.

Test Plan:
- Word write: valid with dst=3, data=16'hBEEF, byte=0, ptr_en=0 -> next cycle REG_wr=2'b11, wr_addr=3, wr_data=BEEF, wb_done=1; following cycle REG_wr=0.
- Byte write: dst=5, data=16'h12AB, byte=1 -> REG_wr=2'b01, wr_addr=5, wr_data=12AB.
- Pointer sequence: dst=1, data=16'h00FF, ptr_en=1, ptr_reg=4, ptr_data=16'h2002 -> cycle1: addr 4, 2002, REG_wr=11, wb_done=0, wb_ready=0; cycle2: addr 1, 00FF, wb_done=1.
- Same register: dst=ptr_reg=2, byte=1, data=16'h0077, ptr_data=16'h1000 -> register 2 ends at 16'h1077.
- Back-to-back: three word requests on consecutive cycles with wb_valid held high -> wb_ready stays 1; three consecutive writes, no gaps.
- Flush/reset: flush during WR_PTR -> data write is never presented, REG_wr=0 next cycle. reset=0 asserted mid-cycle -> REG_wr=0 immediately, without waiting for a clock edge.
